// File: rtl/tnn_ternary_neuron_acc.sv
// tnn_ternary_neuron_acc: accumulates (pos_cnt - neg_cnt) over a frame and emits a thresholded ternary activation.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake; in_last marks the final beat
//   pos_cnt, neg_cnt      unsigned popcounts of +1 / -1 weighted inputs
//   thr_hi, thr_lo        signed thresholds, sampled on the closing beat
//   out_valid/out_ready   result handshake (one-entry output register)
//   act                   01 = +1, 11 = -1, 00 = 0
//   acc_out               saturated frame sum
//   err                   sticky flag: a frame was closed by the beat limit
module tnn_ternary_neuron_acc #(
    parameter int CNT_W     = 4,
    parameter int ACC_W     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [CNT_W-1:0] pos_cnt,
    input  logic [CNT_W-1:0] neg_cnt,
    input  logic [ACC_W-1:0] thr_hi,
    input  logic [ACC_W-1:0] thr_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       act,
    output logic [ACC_W-1:0] acc_out,
    output logic             err
);
    localparam int BC_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc_q, acc_d, acc_out_q, acc_out_d, acc_next;
    logic [BC_W-1:0]         beat_q, beat_d;
    logic [1:0]              act_q, act_d, act_next;
    logic                    out_valid_q, out_valid_d, err_q, err_d;
    logic [CNT_W:0]          delta;
    logic [ACC_W:0]          sum;
    logic                    accept, forced, close;

    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign forced   = beat_q == BC_W'(MAX_BEATS-1);
    assign close    = accept & (in_last | forced);
    // modular subtraction of zero-extended counts yields the signed difference directly
    assign delta    = {1'b0, pos_cnt} - {1'b0, neg_cnt};
    // one guard bit; the top two bits disagreeing means the sum left the ACC_W range
    assign sum      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-CNT_W){delta[CNT_W]}}, delta};
    assign acc_next = (sum[ACC_W:ACC_W-1] == 2'b01) ? ACC_MAX :
                      (sum[ACC_W:ACC_W-1] == 2'b10) ? ACC_MIN : sum[ACC_W-1:0];
    // +1 is tested first so it wins when the thresholds are inverted
    assign act_next = (acc_next > $signed(thr_hi)) ? 2'b01 :
                      (acc_next < $signed(thr_lo)) ? 2'b11 : 2'b00;

    always_comb begin
        acc_d       = accept ? (close ? '0 : acc_next) : acc_q;
        beat_d      = accept ? (close ? '0 : beat_q + BC_W'(1)) : beat_q;
        acc_out_d   = close ? acc_next : acc_out_q;
        act_d       = close ? act_next : act_q;
        out_valid_d = close | (out_valid_q & !out_ready);
        err_d       = err_q | (close & forced & !in_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            beat_q      <= '0;
            acc_out_q   <= '0;
            act_q       <= 2'b00;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            acc_out_q   <= acc_out_d;
            act_q       <= act_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign act       = act_q;
    assign acc_out   = acc_out_q;
    assign err       = err_q;
endmodule

// File: tb/tb_tnn_ternary_neuron_acc.sv
// tb_tnn_ternary_neuron_acc: directed scoreboard bench for tnn_ternary_neuron_acc.
module tb_tnn_ternary_neuron_acc;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, in_last, out_valid, out_ready, err;
    logic [3:0] pos_cnt, neg_cnt;
    logic [7:0] thr_hi, thr_lo, acc_out;
    logic [1:0] act;
    int total = 0, bad = 0;

    typedef struct {
        logic [1:0] act;
        int         acc;
        logic       err;
    } exp_t;
    exp_t sb[$];

    tnn_ternary_neuron_acc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .pos_cnt(pos_cnt), .neg_cnt(neg_cnt),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .out_valid(out_valid),
        .out_ready(out_ready), .act(act), .acc_out(acc_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result got act=%b acc=%0d exp=none", act, $signed(acc_out));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_act", int'(act), int'(e.act));
                chk("res_acc", int'($signed(acc_out)), e.acc);
                chk("res_err", int'(err), int'(e.err));
            end
        end
    end

    task automatic expect_res(input logic [1:0] a, input int acc, input logic e);
        exp_t x;
        x.act = a;
        x.acc = acc;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic set_thr(input int hi, input int lo);
        thr_hi = 8'(hi);
        thr_lo = 8'(lo);
    endtask

    task automatic beat(input int p, input int n, input logic last);
        in_valid = 1'b1;
        pos_cnt  = 4'(p);
        neg_cnt  = 4'(n);
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pos_cnt  = 4'hx;
        neg_cnt  = 4'hx;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        pos_cnt = '0; neg_cnt = '0; set_thr(0, 0);
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_act", int'(act), 0);
        chk("rst_acc_out", int'(acc_out), 0);
        chk("rst_err", int'(err), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // partial frame discarded by asynchronous reset
        beat(5, 1, 0);
        beat(3, 0, 0);
        rst_n = 1'b0;
        #2;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        set_thr(1, -1);
        expect_res(2'b01, 2, 1'b0);
        beat(2, 0, 1);
        idle(1);

        // multi-beat negative sum and one-cycle latency
        set_thr(0, -2);
        beat(1, 4, 0);
        beat(0, 3, 0);
        chk("lat_before_last", int'(out_valid), 0);
        expect_res(2'b11, -6, 1'b0);
        beat(2, 2, 1);
        chk("lat_after_last", int'(out_valid), 1);
        idle(1);

        // dead zone then boundary just above thr_hi
        set_thr(3, 3);
        expect_res(2'b00, 3, 1'b0);
        beat(4, 0, 0);
        beat(0, 1, 1);
        set_thr(2, 3);
        expect_res(2'b01, 3, 1'b0);
        beat(4, 0, 0);
        beat(0, 1, 1);
        idle(1);

        // saturation at +127 then recovery
        set_thr(100, -100);
        repeat (10) beat(15, 0, 0);
        expect_res(2'b01, 112, 1'b0);
        beat(0, 15, 1);
        idle(1);

        // backpressure: hold a result, offer a frame that must not be taken
        out_ready = 1'b0;
        set_thr(5, -5);
        expect_res(2'b00, 1, 1'b0);
        beat(1, 0, 1);
        set_thr(5, 0);
        in_valid = 1'b1; pos_cnt = 4'd0; neg_cnt = 4'd1; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_act_hold", int'(act), 0);
            chk("bp_acc_hold", int'(acc_out), 1);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        expect_res(2'b11, -1, 1'b0);
        #1;
        chk("bp_release_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_replace_valid", int'(out_valid), 1);
        idle(2);

        // forced termination after MAX_BEATS without in_last
        set_thr(10, -10);
        repeat (15) beat(1, 0, 0);
        chk("force_not_yet", int'(out_valid), 0);
        expect_res(2'b01, 16, 1'b1);
        beat(1, 0, 0);
        chk("force_valid", int'(out_valid), 1);
        idle(1);
        set_thr(0, 0);
        expect_res(2'b11, -2, 1'b1);
        beat(0, 2, 1);
        idle(2);
        chk("err_sticky", int'(err), 1);
        rst_n = 1'b0;
        #2;
        chk("err_cleared", int'(err), 0);
        rst_n = 1'b1;
        idle(2);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
